ahb_apb_bridge: RTL and testbench



---
 rtl/ahb_apb_bridge.sv | 137 +++++++++++++
 tb/tb_ahb_apb_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB-Lite slave that turns each accepted AHB beat into one
// APB4 access. The AHB data phase is stretched with HREADYOUT=0 until the APB
// side completes; a PSLVERR is returned as the two-cycle AHB ERROR response.
module ahb_apb_bridge #(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_BITS  = 32,
   parameter int PADDR_BITS = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_BITS-1:0]  HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_BITS-1:0]  HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic [DATA_BITS-1:0]  HRDATA,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [PADDR_BITS-1:0] PADDR,
   output logic [DATA_BITS-1:0]  PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [DATA_BITS-1:0]  PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_t;

   state_t     state;
   logic       accept;
   logic [3:0] strb_dec;

   // Bits the bridge has no use for: burst type, SEQ/NONSEQ distinction and
   // the address bits above the APB window.
   logic unused_in;
   assign unused_in = ^{HBURST, HTRANS[0], HADDR[ADDR_BITS-1:PADDR_BITS]};

   // Address-phase decode: a real transfer to us while the bus is ready,
   // taken only when no transfer is in flight (IDLE, or last ERROR cycle).
   always_comb begin
      accept = HSEL && HTRANS[1] && HREADY && (state == S_IDLE || state == S_ERR2);
   end

   // Byte strobes from size/address; reads never drive strobes. Sizes above
   // word are treated as a full word.
   always_comb begin
      strb_dec = 4'b0000;
      if (HWRITE) begin
         case (HSIZE)
            3'b000:  strb_dec = 4'b0001 << HADDR[1:0];
            3'b001:  strb_dec = HADDR[1] ? 4'b1100 : 4'b0011;
            default: strb_dec = 4'b1111;
         endcase
      end
   end

   // Bridge FSM; every bus output is a flop so HREADYOUT drops right after
   // the accept edge and APB controls are clean state decodes.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= S_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= RESP_OKAY;
         HRDATA    <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PSTRB     <= 4'b0000;
      end else begin
         case (state)
            S_IDLE, S_ERR2: begin
               HRESP <= RESP_OKAY;
               if (accept) begin
                  PADDR     <= HADDR[PADDR_BITS-1:0];
                  PWRITE    <= HWRITE;
                  PSTRB     <= strb_dec;
                  HREADYOUT <= 1'b0;
                  if (HWRITE) begin
                     state <= S_WDATA;
                  end else begin
                     state <= S_SETUP;
                     PSEL  <= 1'b1;
                  end
               end else begin
                  state     <= S_IDLE;
                  HREADYOUT <= 1'b1;
               end
            end
            S_WDATA: begin
               // HWDATA is only valid in this first data-phase cycle
               PWDATA <= HWDATA;
               PSEL   <= 1'b1;
               state  <= S_SETUP;
            end
            S_SETUP: begin
               PENABLE <= 1'b1;
               state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     HRESP <= RESP_ERROR;
                     state <= S_ERR1;
                  end else begin
                     HREADYOUT <= 1'b1;
                     if (!PWRITE) HRDATA <= PRDATA;
                     state <= S_IDLE;
                  end
               end
            end
            S_ERR1: begin
               HREADYOUT <= 1'b1;
               state     <= S_ERR2;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge: directed plus randomized AHB traffic against a memory
// peripheral; expectations come from a word-array reference model.
module tb_ahb_apb_bridge;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic [15:0] PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb_apb_bridge #(.ADDR_BITS(32), .DATA_BITS(32), .PADDR_BITS(16)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // peripheral configuration (written by stimulus) and observations (by peripheral)
   int          cfg_wait = 0;
   bit          cfg_err  = 0;
   int          acc_cnt  = 0;
   int unsigned apb_cnt  = 0;
   int unsigned stab_err = 0;
   bit [31:0]   pmem [64];
   logic [15:0] lg_addr, snap_addr;
   logic [31:0] lg_wdata, snap_wd;
   logic [3:0]  lg_strb, snap_st;
   logic        lg_write, snap_wr;

   // reference model state
   bit [31:0]   ref_mem [64];
   logic [31:0] exp_hrdata;

   // APB memory peripheral: PREADY after cfg_wait ACCESS cycles, optional error
   always @(negedge HCLK) begin
      if (PSEL && !PENABLE) begin
         snap_addr = PADDR; snap_wr = PWRITE; snap_wd = PWDATA; snap_st = PSTRB;
      end
      if (PSEL && PENABLE) begin
         if (PADDR !== snap_addr || PWRITE !== snap_wr || PWDATA !== snap_wd || PSTRB !== snap_st)
            stab_err++;
         if (acc_cnt >= cfg_wait) begin
            PREADY  = 1'b1;
            PSLVERR = cfg_err;
            PRDATA  = cfg_err ? $urandom : pmem[PADDR[7:2]];
            if (PWRITE && !cfg_err)
               for (int b = 0; b < 4; b++)
                  if (PSTRB[b]) pmem[PADDR[7:2]][8*b +: 8] = PWDATA[8*b +: 8];
            apb_cnt++;
            lg_addr = PADDR; lg_wdata = PWDATA; lg_strb = PSTRB; lg_write = PWRITE;
            acc_cnt = 0;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            acc_cnt++;
         end
      end else begin
         PREADY  = 1'($urandom_range(0, 1));
         PSLVERR = 1'($urandom_range(0, 1));
         PRDATA  = $urandom;
         acc_cnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe mask as contiguous byte lanes of the access size at its aligned offset
   function automatic logic [3:0] exp_strb(input bit wr, input logic [2:0] sz, input logic [31:0] a);
      int nb, off;
      if (!wr) return 4'b0000;
      nb  = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
      off = int'(a[1:0]) & ~(nb - 1);
      return 4'(((1 << nb) - 1) << off);
   endfunction

   // Non-transfers on the bus must not be accepted
   task automatic ahb_idle(input int n);
      int unsigned c0;
      c0 = apb_cnt;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0: begin HSEL = 1'b0; HTRANS = 2'b10; end
            1: begin HSEL = 1'b1; HTRANS = 2'b01; end
            default: begin HSEL = 1'b1; HTRANS = 2'b00; end
         endcase
         HADDR = $urandom; HWRITE = 1'($urandom);
         @(posedge HCLK); #1;
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      chk("idle_hreadyout", HREADYOUT, 1'b1);
      chk("idle_hresp", HRESP, 2'b00);
      chk("idle_no_apb", apb_cnt - c0, 0);
   endtask

   // One AHB transfer; entered and left at #1 after an edge with HREADYOUT=1,
   // so a following call presents its address phase in the completion cycle.
   task automatic ahb_xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                           input logic [31:0] wdata, input int nwait, input bit err);
      int unsigned c0;
      int          low, errlow, exp_low;
      logic [3:0]  m;
      c0 = apb_cnt;
      cfg_wait = nwait; cfg_err = err;
      m = exp_strb(wr, size, addr);
      exp_low = (wr ? 3 : 2) + nwait + (err ? 1 : 0);
      HSEL = 1'b1; HADDR = addr; HTRANS = 2'($urandom_range(2, 3));
      HWRITE = wr; HSIZE = size; HBURST = 3'($urandom);
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom);
      HWDATA = wr ? wdata : $urandom;
      low = 0; errlow = 0;
      while (HREADYOUT !== 1'b1 && low < 60) begin
         if (HRESP === 2'b01) errlow++;
         low++;
         @(posedge HCLK); #1;
      end
      chk("wait_states", low, exp_low);
      chk("err1_cycles", errlow, err ? 1 : 0);
      chk("hresp_done", HRESP, err ? 2'b01 : 2'b00);
      chk("apb_count", apb_cnt - c0, 1);
      chk("paddr", lg_addr, addr[15:0]);
      chk("pwrite", lg_write, wr);
      chk("pstrb", lg_strb, m);
      if (wr) chk("pwdata", lg_wdata, wdata);
      if (!err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (m[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            exp_hrdata = ref_mem[addr[7:2]];
         end
      end
      chk("hrdata", HRDATA, exp_hrdata);
   endtask

   initial begin
      int cnt;
      HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HBURST = 3'b000; HWDATA = '0;
      exp_hrdata = '0;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_hreadyout", HREADYOUT, 1'b1);
      chk("rst_hresp", HRESP, 2'b00);
      chk("rst_hrdata", HRDATA, 32'h0);
      chk("rst_psel_penable", {PSEL, PENABLE, PWRITE}, 3'b000);
      chk("rst_paddr", PADDR, 16'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_pstrb", PSTRB, 4'h0);
      HRESET = 1'b0;
      ahb_idle(2);

      // word write, then a read with two PREADY-low cycles
      ahb_xfer(32'h4, 1'b1, 3'b010, 32'h1234ABCD, 0, 1'b0);
      ahb_idle(1);
      ahb_xfer(32'h8, 1'b1, 3'b010, 32'hCAFE0001, 0, 1'b0);
      ahb_idle(1);
      ahb_xfer(32'h8, 1'b0, 3'b010, 32'h0, 2, 1'b0);
      chk("read_cafe", HRDATA, 32'hCAFE0001);
      ahb_idle(1);

      // halfword upper lanes, then top byte lane
      ahb_xfer(32'h6, 1'b1, 3'b001, 32'hBEEF0000, 0, 1'b0);
      chk("hw_strb", lg_strb, 4'b1100);
      ahb_xfer(32'h3, 1'b1, 3'b000, 32'h5A000000, 1, 1'b0);
      chk("byte_strb", lg_strb, 4'b1000);
      ahb_idle(1);

      // errored read leaves HRDATA alone, next read is OKAY
      ahb_xfer(32'hC, 1'b0, 3'b010, 32'h0, 0, 1'b1);
      chk("err_keeps_hrdata", HRDATA, 32'hCAFE0001);
      ahb_idle(1);
      ahb_xfer(32'h0, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      chk("read0_word", HRDATA, 32'h5A00_0000);

      // back-to-back write/read through the memory peripheral
      ahb_xfer(32'h10, 1'b1, 3'b010, 32'hA5A5_0F0F, 0, 1'b0);
      ahb_xfer(32'h10, 1'b0, 3'b010, 32'h0, 0, 1'b0);
      chk("b2b_readback", HRDATA, 32'hA5A5_0F0F);
      ahb_idle(1);

      // randomized traffic, random error injection and back-to-back gaps
      for (int i = 0; i < 60; i++) begin
         ahb_xfer($urandom_range(0, 255), 1'($urandom), 3'($urandom), $urandom,
                  $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 1) == 1) ahb_idle($urandom_range(1, 2));
      end
      ahb_idle(1);

      // reset in the middle of a write's ACCESS phase
      cfg_wait = 20; cfg_err = 1'b0;
      HSEL = 1'b1; HADDR = 32'h20; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h55AA_33CC;
      cnt = 0;
      while (!(PSEL === 1'b1 && PENABLE === 1'b1) && cnt < 20) begin
         @(posedge HCLK); #1;
         cnt++;
      end
      chk("rst_reached_access", {PSEL, PENABLE}, 2'b11);
      HRESET = 1'b1;
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      exp_hrdata = '0;
      chk("midrst_psel_penable", {PSEL, PENABLE}, 2'b00);
      chk("midrst_hreadyout", HREADYOUT, 1'b1);
      chk("midrst_hresp", HRESP, 2'b00);
      chk("midrst_pwdata", PWDATA, 32'h0);
      chk("midrst_hrdata", HRDATA, 32'h0);
      ahb_xfer(32'h20, 1'b0, 3'b010, 32'h0, 1, 1'b0);
      ahb_idle(1);

      chk("apb_stability", stab_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
